l1b_host_regfile: RTL and testbench



---
 rtl/l1b_pkg.sv | 27 ++
 rtl/l1b_sync_edge.sv | 37 +++
 rtl/l1b_host_regfile.sv | 176 +++++++++++++++++
 tb/tb_l1b_host_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/l1b_pkg.sv
// Shared types and constants for the L1B host-bus register file.
// Holds the host-phase FSM encoding, default geometry and a width helper.
package l1b_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } l1b_state_e;

    localparam logic [15:0] DEF_BASE_ADDR = 16'hFE40;
    localparam int          DEF_REG_W     = 32'sd8;

    // Index width for a register window; never narrower than one bit.
    function automatic int l1b_clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/l1b_sync_edge.sv
// Multi-flop synchroniser for the host phase plus single-cycle rise/fall detection.
// All flops clear asynchronously so no spurious edge is seen after reset.
module l1b_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   phi2_d_r;
    logic                   phi2_s;

    if (SYNC_STAGES < 32'sd2) begin : g_bad_stages
        $error("l1b_sync_edge: SYNC_STAGES must be at least 2");
    end

    assign phi2_s = sync_r[SYNC_STAGES-1];

    // Shift the asynchronous level in and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r   <= '0;
            phi2_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], din};
            phi2_d_r <= phi2_s;
        end
    end

    assign rise = phi2_s & ~phi2_d_r;
    assign fall = ~phi2_s & phi2_d_r;

endmodule

// File: rtl/l1b_host_regfile.sv
// Host-bus register window for the L1B CPLD: decodes NUM_REGS registers at BASE_ADDR,
// commits writes at the end of the host phase and supports per-register write-once locks.
module l1b_host_regfile
    import l1b_pkg::*;
#(
    parameter int                  ADDR_W      = 32'sd16,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
    parameter int                  NUM_REGS    = 32'sd4,
    parameter int                  REG_W       = DEF_REG_W,
    parameter logic [REG_W-1:0]    RESET_VAL   = '0,
    parameter logic [NUM_REGS-1:0] LOCK_MASK   = '0,
    parameter int                  SYNC_STAGES = 32'sd2
) (
    input  logic                      hsclk,
    input  logic                      reset,
    input  logic                      bbc_phi2,
    input  logic [ADDR_W-1:0]         cpu_a,
    input  logic [REG_W-1:0]          cpu_d,
    input  logic                      cpu_rnw,
    input  logic                      cpu_vda,
    output logic [NUM_REGS*REG_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]       reg_wr_stb,
    output logic [REG_W-1:0]          rd_data,
    output logic                      lat_en,
    output logic                      busy,
    output logic                      lock_viol
);

    localparam int              IDX_W  = l1b_clog2(NUM_REGS);
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(NUM_REGS);

    if ((NUM_REGS < 32'sd1) || (NUM_REGS > 32'sd16)) begin : g_bad_num_regs
        $error("l1b_host_regfile: NUM_REGS must be 1..16");
    end
    if ((64'(BASE_ADDR) + 64'(NUM_REGS)) > (64'd1 << ADDR_W)) begin : g_bad_window
        $error("l1b_host_regfile: register window exceeds the address space");
    end

    logic             rise_s;
    logic             fall_s;
    logic             hit_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] idx_r;
    l1b_state_e       state_r;
    l1b_state_e       state_next_s;
    logic             cap_start_s;
    logic             rd_hit_s;
    logic             lat_set_s;
    logic             lat_clr_s;

    logic [REG_W-1:0]    regs_r [NUM_REGS];
    logic [REG_W-1:0]    hold_r;
    logic [REG_W-1:0]    rd_data_r;
    logic [NUM_REGS-1:0] locked_r;
    logic [NUM_REGS-1:0] wr_stb_r;
    logic                lat_en_r;
    logic                busy_r;
    logic                lock_viol_r;

    l1b_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (hsclk),
        .rst (reset),
        .din (bbc_phi2),
        .rise(rise_s),
        .fall(fall_s)
    );

    // The window test is done one bit wider so BASE_ADDR+NUM_REGS cannot wrap.
    assign hit_s = cpu_vda & ({1'b0, cpu_a} >= WIN_LO) & ({1'b0, cpu_a} < WIN_HI);
    assign idx_s = IDX_W'(cpu_a - BASE_ADDR);

    // Next-state and per-cycle control decode for the host-phase FSM.
    always_comb begin
        state_next_s = state_r;
        cap_start_s  = 1'b0;
        rd_hit_s     = 1'b0;
        lat_set_s    = 1'b0;
        lat_clr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    lat_set_s = 1'b1;
                    if (hit_s & ~cpu_rnw) begin
                        cap_start_s  = 1'b1;
                        state_next_s = CAPTURE;
                    end else if (hit_s & cpu_rnw) begin
                        rd_hit_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (fall_s) begin
                    lat_clr_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPTURE: begin
                if (fall_s) begin
                    lat_clr_s    = 1'b1;
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = CAPTURE;
                end
            end
            COMMIT: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, registers, locks and all registered outputs.
    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            hold_r      <= '0;
            rd_data_r   <= '0;
            locked_r    <= '0;
            wr_stb_r    <= '0;
            lat_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            lock_viol_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != IDLE);
            wr_stb_r    <= '0;
            lock_viol_r <= 1'b0;
            if (lat_set_s) begin
                lat_en_r <= 1'b1;
            end else if (lat_clr_s) begin
                lat_en_r <= 1'b0;
            end
            if (cap_start_s) begin
                idx_r <= idx_s;
            end
            // Sampling continues through the cycle that sees the fall, so the last data wins.
            if (state_r == CAPTURE) begin
                hold_r <= cpu_d;
            end
            if (rd_hit_s) begin
                rd_data_r <= regs_r[idx_s];
            end
            if (state_r == COMMIT) begin
                if (locked_r[idx_r]) begin
                    lock_viol_r <= 1'b1;
                end else begin
                    regs_r[idx_r]   <= hold_r;
                    wr_stb_r[idx_r] <= 1'b1;
                end
                if (LOCK_MASK[idx_r]) begin
                    locked_r[idx_r] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*REG_W +: REG_W] = regs_r[g];
    end

    assign reg_wr_stb = wr_stb_r;
    assign rd_data    = rd_data_r;
    assign lat_en     = lat_en_r;
    assign busy       = busy_r;
    assign lock_viol  = lock_viol_r;

endmodule

// File: tb/tb_l1b_host_regfile.sv
// Directed bench for l1b_host_regfile (4 registers at FE40, register 0 write-once).
// Inputs change and outputs are sampled on the falling edge of hsclk.
module tb_l1b_host_regfile;

    logic        hsclk = 1'b0;
    logic        reset;
    logic        bbc_phi2;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_rnw;
    logic        cpu_vda;
    logic [31:0] reg_q;
    logic [3:0]  reg_wr_stb;
    logic [7:0]  rd_data;
    logic        lat_en;
    logic        busy;
    logic        lock_viol;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q    = 32'h0;

    logic [15:0] nh_addr [3] = '{16'hFE44, 16'hFE40, 16'hFE3F};
    logic        nh_vda  [3] = '{1'b1, 1'b0, 1'b1};

    always #5 hsclk = ~hsclk;

    l1b_host_regfile #(
        .LOCK_MASK(4'b0001)
    ) dut (
        .hsclk     (hsclk),
        .reset     (reset),
        .bbc_phi2  (bbc_phi2),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_rnw   (cpu_rnw),
        .cpu_vda   (cpu_vda),
        .reg_q     (reg_q),
        .reg_wr_stb(reg_wr_stb),
        .rd_data   (rd_data),
        .lat_en    (lat_en),
        .busy      (busy),
        .lock_viol (lock_viol)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge hsclk);
    endtask

    // Drive one host phase; returns at the falling-edge slot where phi2 goes low.
    task automatic phase(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                         input logic vda, input int hi);
        cpu_a    = a;
        cpu_d    = d;
        cpu_rnw  = rnw;
        cpu_vda  = vda;
        bbc_phi2 = 1'b1;
        tick(hi);
        bbc_phi2 = 1'b0;
    endtask

    // Fall at slot m-1/m: COMMIT at edge m+2, registers and strobe at edge m+3.
    task automatic finish_write(input string tag, input logic exp_busy, input logic [31:0] new_q,
                                input logic [3:0] exp_stb, input logic exp_viol);
        tick(3);
        check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check_eq({tag, "_q_early"}, reg_q, exp_q);
        check_eq({tag, "_stb_early"}, 32'(reg_wr_stb), 32'h0);
        tick(1);
        check_eq({tag, "_q"}, reg_q, new_q);
        check_eq({tag, "_stb"}, 32'(reg_wr_stb), 32'(exp_stb));
        check_eq({tag, "_viol"}, 32'(lock_viol), 32'(exp_viol));
        check_eq({tag, "_idle"}, 32'(busy), 32'h0);
        tick(1);
        check_eq({tag, "_stb_end"}, 32'(reg_wr_stb), 32'h0);
        check_eq({tag, "_viol_end"}, 32'(lock_viol), 32'h0);
        exp_q = new_q;
        tick(2);
    endtask

    initial begin
        reset    = 1'b1;
        bbc_phi2 = 1'b0;
        cpu_a    = 16'h0000;
        cpu_d    = 8'h00;
        cpu_rnw  = 1'b1;
        cpu_vda  = 1'b0;
        @(negedge hsclk);

        for (int i = 0; i < 6; i++) begin
            bbc_phi2 = ~bbc_phi2;
            tick(1);
        end
        check_eq("rst_q", reg_q, 32'h0);
        check_eq("rst_stb", 32'(reg_wr_stb), 32'h0);
        check_eq("rst_lat", 32'(lat_en), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rd", 32'(rd_data), 32'h0);
        check_eq("rst_viol", 32'(lock_viol), 32'h0);
        reset = 1'b0;
        tick(4);

        // lat_en tracks phi2 three edges late; a non-hit phase never leaves IDLE
        bbc_phi2 = 1'b1;
        tick(2);
        check_eq("lat_rise_early", 32'(lat_en), 32'h0);
        tick(1);
        check_eq("lat_rise", 32'(lat_en), 32'h1);
        tick(3);
        bbc_phi2 = 1'b0;
        tick(2);
        check_eq("lat_fall_early", 32'(lat_en), 32'h1);
        tick(1);
        check_eq("lat_fall", 32'(lat_en), 32'h0);
        check_eq("lat_busy", 32'(busy), 32'h0);
        tick(2);

        phase(16'hFE41, 8'hA5, 1'b0, 1'b1, 8);
        finish_write("wr_fe41", 1'b1, 32'h0000_A500, 4'b0010, 1'b0);

        // Data changes three cycles before fall; a change during COMMIT must not leak in
        cpu_a    = 16'hFE43;
        cpu_d    = 8'h11;
        cpu_rnw  = 1'b0;
        cpu_vda  = 1'b1;
        bbc_phi2 = 1'b1;
        tick(5);
        cpu_d = 8'h22;
        tick(3);
        bbc_phi2 = 1'b0;
        tick(3);
        cpu_d = 8'h99;
        tick(1);
        check_eq("wr_fe43_q", reg_q, 32'h2200_A500);
        check_eq("wr_fe43_stb", 32'(reg_wr_stb), 32'h8);
        exp_q = 32'h2200_A500;
        tick(3);

        phase(16'hFE42, 8'h5A, 1'b0, 1'b1, 1);
        finish_write("wr_short", 1'b1, 32'h225A_A500, 4'b0100, 1'b0);

        check_eq("rd_pre", 32'(rd_data), 32'h0);
        cpu_a    = 16'hFE42;
        cpu_rnw  = 1'b1;
        cpu_vda  = 1'b1;
        bbc_phi2 = 1'b1;
        tick(2);
        check_eq("rd_early", 32'(rd_data), 32'h0);
        tick(1);
        check_eq("rd_data", 32'(rd_data), 32'h5A);
        check_eq("rd_busy", 32'(busy), 32'h0);
        tick(2);
        bbc_phi2 = 1'b0;
        tick(4);
        check_eq("rd_stb", 32'(reg_wr_stb), 32'h0);
        check_eq("rd_q", reg_q, exp_q);
        check_eq("rd_hold", 32'(rd_data), 32'h5A);
        tick(2);

        for (int i = 0; i < 3; i++) begin
            phase(nh_addr[i], 8'hFF, 1'b0, nh_vda[i], 4);
            finish_write($sformatf("nohit%0d", i), 1'b0, exp_q, 4'b0000, 1'b0);
        end

        phase(16'hFE40, 8'h01, 1'b0, 1'b1, 4);
        finish_write("lock_w1", 1'b1, 32'h225A_A501, 4'b0001, 1'b0);
        phase(16'hFE40, 8'h02, 1'b0, 1'b1, 4);
        finish_write("lock_w2", 1'b1, 32'h225A_A501, 4'b0000, 1'b1);

        reset = 1'b1;
        #1;
        check_eq("lock_rst_q", reg_q, 32'h0);
        tick(2);
        reset = 1'b0;
        exp_q = 32'h0;
        tick(2);
        phase(16'hFE40, 8'h03, 1'b0, 1'b1, 4);
        finish_write("lock_after_rst", 1'b1, 32'h0000_0003, 4'b0001, 1'b0);

        // Reset lands while a write to FE42 is being captured
        cpu_a    = 16'hFE42;
        cpu_d    = 8'h77;
        cpu_rnw  = 1'b0;
        cpu_vda  = 1'b1;
        bbc_phi2 = 1'b1;
        tick(4);
        check_eq("cap_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("cap_rst_busy", 32'(busy), 32'h0);
        check_eq("cap_rst_lat", 32'(lat_en), 32'h0);
        tick(1);
        bbc_phi2 = 1'b0;
        tick(2);
        reset = 1'b0;
        exp_q = 32'h0;
        tick(5);
        check_eq("cap_after_stb", 32'(reg_wr_stb), 32'h0);
        check_eq("cap_after_q", reg_q, 32'h0);
        check_eq("cap_after_busy", 32'(busy), 32'h0);
        phase(16'hFE42, 8'h66, 1'b0, 1'b1, 4);
        finish_write("cap_next_wr", 1'b1, 32'h0066_0000, 4'b0100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
